// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and constants for the multicycle control FSM and its output decoder.
package multicycle_ctrl_fsm_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMREAD,
      MEMWB,
      MEMWRITE,
      EXECUTER,
      EXECUTEI,
      ALUWB,
      BRANCH,
      UNKNOWN
   } state_t;

   // Instruction op field
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   // Funct bit positions: I selects DP immediate, L selects LDR over STR
   localparam int FUNCT_I_BIT = 5;
   localparam int FUNCT_L_BIT = 0;

   // Datapath mux selects
   localparam logic [1:0] SRCA_REG   = 2'b00;
   localparam logic [1:0] SRCA_PC    = 2'b01;
   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   // Per-state control word. ir_write/next_pc are still ANDed with MemReady by the
   // top; retire marks states that complete an instruction.
   typedef struct packed {
      logic       ir_write;
      logic       next_pc;
      logic       reg_w;
      logic       mem_w;
      logic       branch;
      logic       alu_op;
      logic       adr_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic       retire;
      logic       illegal;
   } ctrl_word_t;

   // FETCH decode doubles as the reset value of the registered control word
   localparam ctrl_word_t CTRL_FETCH = '{
      ir_write:   1'b1,
      next_pc:    1'b1,
      reg_w:      1'b0,
      mem_w:      1'b0,
      branch:     1'b0,
      alu_op:     1'b0,
      adr_src:    1'b0,
      alu_src_a:  SRCA_PC,
      alu_src_b:  SRCB_FOUR,
      result_src: RES_ALU,
      retire:     1'b0,
      illegal:    1'b0
   };

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control/handshake bundle between the multicycle datapath and its control FSM.
interface multicycle_ctrl_fsm_if #(parameter int CNT_W = 32);

   logic [1:0]       Op;
   logic [5:0]       Funct;
   logic             MemReady;
   logic             IRWrite;
   logic             NextPC;
   logic             RegW;
   logic             MemW;
   logic             Branch;
   logic             ALUOp;
   logic             AdrSrc;
   logic [1:0]       ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [1:0]       ResultSrc;
   logic             InstrDone;
   logic             Illegal;
   logic [CNT_W-1:0] RetiredCnt;

   // Datapath side: supplies instruction fields and memory handshake
   modport master (
      output Op, Funct, MemReady,
      input  IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
             ALUSrcA, ALUSrcB, ResultSrc, InstrDone, Illegal, RetiredCnt
   );

   // Controller side
   modport slave (
      input  Op, Funct, MemReady,
      output IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
             ALUSrcA, ALUSrcB, ResultSrc, InstrDone, Illegal, RetiredCnt
   );

endinterface

// File: rtl/multicycle_ctrl_fsm_ctrl_out_decode.sv
// Pure state -> control word decode, kept separate so pipelined control can reuse it.
module multicycle_ctrl_fsm_ctrl_out_decode
   import multicycle_ctrl_fsm_pkg::*;
(
   input  state_t     state_i,
   output ctrl_word_t ctrl_o
);

   // Moore decode of each state; anything not listed stays 0
   always_comb begin
      // NOTE: default the whole word first so every path assigns every bit (no latch).
      ctrl_o = '0;
      case (state_i)
         FETCH: ctrl_o = CTRL_FETCH;
         DECODE: begin
            ctrl_o.alu_src_a  = SRCA_PC;
            ctrl_o.alu_src_b  = SRCB_FOUR;
            ctrl_o.result_src = RES_ALU;
         end
         MEMADR: begin
            ctrl_o.alu_src_a = SRCA_REG;
            ctrl_o.alu_src_b = SRCB_IMM;
         end
         MEMREAD: begin
            ctrl_o.adr_src    = 1'b1;
            ctrl_o.result_src = RES_ALUOUT;
         end
         MEMWB: begin
            ctrl_o.result_src = RES_DATA;
            ctrl_o.reg_w      = 1'b1;
            ctrl_o.retire     = 1'b1;
         end
         MEMWRITE: begin
            ctrl_o.adr_src    = 1'b1;
            ctrl_o.result_src = RES_ALUOUT;
            ctrl_o.mem_w      = 1'b1;
            ctrl_o.retire     = 1'b1;
         end
         EXECUTER: begin
            ctrl_o.alu_src_a = SRCA_REG;
            ctrl_o.alu_src_b = SRCB_REG;
            ctrl_o.alu_op    = 1'b1;
         end
         EXECUTEI: begin
            ctrl_o.alu_src_a = SRCA_REG;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = 1'b1;
         end
         ALUWB: begin
            ctrl_o.result_src = RES_ALUOUT;
            ctrl_o.reg_w      = 1'b1;
            ctrl_o.retire     = 1'b1;
         end
         BRANCH: begin
            ctrl_o.alu_src_a  = SRCA_REG;
            ctrl_o.alu_src_b  = SRCB_IMM;
            ctrl_o.result_src = RES_ALU;
            ctrl_o.branch     = 1'b1;
            ctrl_o.retire     = 1'b1;
         end
         UNKNOWN: ctrl_o.illegal = 1'b1;
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main multicycle control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WB, waits on
// MemReady, counts retired instructions and flags unimplemented opcodes.
module multicycle_ctrl_fsm #(
   parameter int CNT_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   multicycle_ctrl_fsm_if.slave  bus
);
   import multicycle_ctrl_fsm_pkg::*;

   state_t           state_q, state_d;
   ctrl_word_t       ctrl_q, ctrl_d;
   logic [CNT_W-1:0] cnt_q;
   logic             instr_done;
   logic             unused_funct;

   // Next-state selection; MemReady only matters in FETCH/MEMREAD/MEMWRITE
   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:    state_d = bus.MemReady ? DECODE : FETCH;
         DECODE: begin
            case (bus.Op)
               OP_DP:   state_d = bus.Funct[FUNCT_I_BIT] ? EXECUTEI : EXECUTER;
               OP_MEM:  state_d = MEMADR;
               OP_BR:   state_d = BRANCH;
               default: state_d = UNKNOWN;
            endcase
         end
         MEMADR:   state_d = bus.Funct[FUNCT_L_BIT] ? MEMREAD : MEMWRITE;
         MEMREAD:  state_d = bus.MemReady ? MEMWB : MEMREAD;
         MEMWB:    state_d = FETCH;
         MEMWRITE: state_d = bus.MemReady ? FETCH : MEMWRITE;
         EXECUTER: state_d = ALUWB;
         EXECUTEI: state_d = ALUWB;
         ALUWB:    state_d = FETCH;
         BRANCH:   state_d = FETCH;
         UNKNOWN:  state_d = FETCH;
         default:  state_d = FETCH;
      endcase
   end

   // Decode the upcoming state so the control word can be registered alongside it
   multicycle_ctrl_fsm_ctrl_out_decode u_decode (
      .state_i (state_d),
      .ctrl_o  (ctrl_d)
   );

   // State, registered control word and retired-instruction counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH;
         ctrl_q  <= CTRL_FETCH;
         cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values together.
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         if (instr_done) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // A store retires only on the cycle memory accepts it; other retire states are unconditional
   assign instr_done = ctrl_q.retire & (~ctrl_q.mem_w | bus.MemReady);

   // Fetch strobes follow MemReady but are forced low while reset is held
   assign bus.IRWrite    = ctrl_q.ir_write & bus.MemReady & reset;
   assign bus.NextPC     = ctrl_q.next_pc  & bus.MemReady & reset;
   assign bus.RegW       = ctrl_q.reg_w;
   assign bus.MemW       = ctrl_q.mem_w;
   assign bus.Branch     = ctrl_q.branch;
   assign bus.ALUOp      = ctrl_q.alu_op;
   assign bus.AdrSrc     = ctrl_q.adr_src;
   assign bus.ALUSrcA    = ctrl_q.alu_src_a;
   assign bus.ALUSrcB    = ctrl_q.alu_src_b;
   assign bus.ResultSrc  = ctrl_q.result_src;
   assign bus.InstrDone  = instr_done;
   assign bus.Illegal    = ctrl_q.illegal;
   assign bus.RetiredCnt = cnt_q;

   // Middle Funct bits belong to the ALU decoder, not to sequencing
   assign unused_funct = ^bus.Funct[4:1];

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: each instruction's expected profile (length,
// strobe counts, retire/illegal cycle, counter) is derived from its Op/Funct and
// the planned MemReady stalls, then compared with what the DUT produced.
module tb_multicycle_ctrl_fsm;

   localparam int CNT_W   = 4;
   localparam int CNT_MOD = 1 << CNT_W;

   logic clk = 1'b0;
   logic reset;

   int checks  = 0;
   int passed  = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   multicycle_ctrl_fsm_if #(.CNT_W(CNT_W)) bus ();

   multicycle_ctrl_fsm #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Run one instruction: fw fetch stall cycles, mw memory stall cycles
   task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] funct,
                            input int fw, input int mw);
      bit   is_dp, is_ld, is_st, is_br, is_ill;
      int   rest, total, ms;
      int   ir_n, ir_at, np_n, rw_n, rw_at, mw_n, br_n, dn_n, dn_at, il_n, il_at, ao_n;
      logic [1:0] rw_res, ao_srcb;
      logic [7:0] fetch_sig;
      int   rw_exp, mw_exp;
      logic [1:0] rs_exp, srcb_exp;

      is_dp  = (op == 2'b00);
      is_ld  = (op == 2'b01) && funct[0];
      is_st  = (op == 2'b01) && !funct[0];
      is_br  = (op == 2'b10);
      is_ill = (op == 2'b11);
      // DP 4, LDR 5, STR 4, B 3, illegal 3 cycles plus stalls
      rest  = is_dp ? 3 : is_ld ? 4 + mw : is_st ? 3 + mw : 2;
      total = fw + 1 + rest;
      ms    = fw + 3;
      ir_n = 0; ir_at = -1; np_n = 0; rw_n = 0; rw_at = -1; mw_n = 0; br_n = 0;
      dn_n = 0; dn_at = -1; il_n = 0; il_at = -1; ao_n = 0;
      rw_res = 2'b11; ao_srcb = 2'b11; fetch_sig = '0;

      for (int c = 0; c < total; c++) begin
         logic rdy;
         if (c < fw)                            rdy = 1'b0;
         else if (c == fw)                      rdy = 1'b1;
         else if ((is_ld || is_st) && c >= ms)  rdy = (c == ms + mw);
         else                                   rdy = 1'($urandom_range(0, 1));
         bus.MemReady = rdy;
         if (c <= fw) begin
            bus.Op    = 2'($urandom);
            bus.Funct = 6'($urandom);
         end else begin
            bus.Op    = op;
            bus.Funct = funct;
         end
         @(negedge clk);
         if (c == 0) fetch_sig = {bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUOp};
         if (bus.IRWrite)   begin ir_n++; ir_at = c; end
         if (bus.NextPC)    np_n++;
         if (bus.RegW)      begin rw_n++; rw_at = c; rw_res = bus.ResultSrc; end
         if (bus.MemW)      mw_n++;
         if (bus.Branch)    br_n++;
         if (bus.InstrDone) begin dn_n++; dn_at = c; end
         if (bus.Illegal)   begin il_n++; il_at = c; end
         if (bus.ALUOp)     begin ao_n++; ao_srcb = bus.ALUSrcB; end
         @(posedge clk);
         #1;
      end

      if (!is_ill) exp_cnt = (exp_cnt + 1) % CNT_MOD;
      rw_exp   = (is_dp || is_ld) ? 1 : 0;
      mw_exp   = is_st ? mw + 1 : 0;
      rs_exp   = is_ld ? 2'b01 : 2'b00;
      srcb_exp = funct[5] ? 2'b01 : 2'b00;

      checks++;
      if (fetch_sig !== 8'b0_01_10_10_0)
         $display("FAIL %s fetch_ctrl: got %b expected %b", name, fetch_sig, 8'b0_01_10_10_0);
      else passed++;
      checks++;
      if (ir_n != 1 || ir_at != fw)
         $display("FAIL %s irwrite: got %0d pulses at %0d expected 1 at %0d", name, ir_n, ir_at, fw);
      else passed++;
      checks++;
      if (np_n != 1) $display("FAIL %s nextpc: got %0d pulses expected 1", name, np_n);
      else passed++;
      checks++;
      if (rw_n != rw_exp || rw_at != (rw_exp == 1 ? total - 1 : -1))
         $display("FAIL %s regw: got %0d at %0d expected %0d at %0d", name, rw_n, rw_at, rw_exp,
                  (rw_exp == 1 ? total - 1 : -1));
      else passed++;
      if (rw_exp == 1) begin
         checks++;
         if (rw_res !== rs_exp)
            $display("FAIL %s resultsrc_wb: got %b expected %b", name, rw_res, rs_exp);
         else passed++;
      end
      checks++;
      if (mw_n != mw_exp) $display("FAIL %s memw: got %0d cycles expected %0d", name, mw_n, mw_exp);
      else passed++;
      checks++;
      if (br_n != int'(is_br)) $display("FAIL %s branch: got %0d cycles expected %0d", name, br_n, int'(is_br));
      else passed++;
      checks++;
      if (dn_n != int'(!is_ill) || dn_at != (is_ill ? -1 : total - 1))
         $display("FAIL %s instrdone: got %0d at %0d expected %0d at %0d", name, dn_n, dn_at,
                  int'(!is_ill), (is_ill ? -1 : total - 1));
      else passed++;
      checks++;
      if (il_n != int'(is_ill) || il_at != (is_ill ? total - 1 : -1))
         $display("FAIL %s illegal: got %0d at %0d expected %0d at %0d", name, il_n, il_at,
                  int'(is_ill), (is_ill ? total - 1 : -1));
      else passed++;
      checks++;
      if (ao_n != int'(is_dp) || (is_dp && ao_srcb !== srcb_exp))
         $display("FAIL %s aluop: got %0d cycles srcb %b expected %0d srcb %b", name, ao_n, ao_srcb,
                  int'(is_dp), srcb_exp);
      else passed++;
      checks++;
      if (int'(bus.RetiredCnt) != exp_cnt)
         $display("FAIL %s retiredcnt: got %0d expected %0d", name, bus.RetiredCnt, exp_cnt);
      else passed++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.MemReady = 1'b1;
      bus.Op = 2'b01;
      bus.Funct = 6'b000000;
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.IRWrite, bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.InstrDone, bus.Illegal} !== 7'b0)
         $display("FAIL reset_strobes: got %b expected 0000000",
                  {bus.IRWrite, bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.InstrDone, bus.Illegal});
      else passed++;
      checks++;
      if ({bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUOp} !== 8'b0_01_10_10_0)
         $display("FAIL reset_fetch_ctrl: got %b expected 00110100",
                  {bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUOp});
      else passed++;
      checks++;
      if (bus.RetiredCnt !== '0) $display("FAIL reset_cnt: got %0d expected 0", bus.RetiredCnt);
      else passed++;
      @(posedge clk);
      #1 reset = 1'b1;
      exp_cnt = 0;
   endtask

   task automatic test_add();
      run_instr("add", 2'b00, 6'b001000, 0, 0);
   endtask

   task automatic test_dp_imm_fetch_stall();
      run_instr("dp_imm_stall", 2'b00, 6'b100100, 2, 0);
   endtask

   task automatic test_ldr_stall();
      run_instr("ldr_stall", 2'b01, 6'b011001, 0, 3);
   endtask

   task automatic test_str_stall();
      run_instr("str_stall", 2'b01, 6'b011000, 0, 2);
   endtask

   task automatic test_branch();
      run_instr("branch", 2'b10, 6'($urandom), 0, 0);
   endtask

   task automatic test_illegal();
      run_instr("illegal", 2'b11, 6'($urandom), 1, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++)
         run_instr("random", 2'($urandom), 6'($urandom), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 3)));
   endtask

   // Reset lands while a store is stalled in MEMWRITE
   task automatic test_reset_mid_write();
      run_instr("pre_str", 2'b00, 6'b000010, 0, 0);
      bus.Op = 2'b01;
      bus.Funct = 6'b000000;
      bus.MemReady = 1'b1;
      @(posedge clk); #1;                        // FETCH accepted
      bus.MemReady = 1'($urandom_range(0, 1));
      @(posedge clk); #1;                        // DECODE
      @(posedge clk); #1;                        // MEMADR
      bus.MemReady = 1'b0;
      @(posedge clk); #1;                        // first MEMWRITE stall cycle done
      @(negedge clk);
      checks++;
      if (bus.MemW !== 1'b1) $display("FAIL midrst_memw_before: got %b expected 1", bus.MemW);
      else passed++;
      #2 reset = 1'b0;
      bus.MemReady = 1'b1;
      #1;
      checks++;
      if ({bus.MemW, bus.IRWrite, bus.NextPC, bus.InstrDone} !== 4'b0)
         $display("FAIL midrst_strobes: got %b expected 0000",
                  {bus.MemW, bus.IRWrite, bus.NextPC, bus.InstrDone});
      else passed++;
      checks++;
      if (bus.RetiredCnt !== '0) $display("FAIL midrst_cnt: got %0d expected 0", bus.RetiredCnt);
      else passed++;
      @(negedge clk);
      checks++;
      if ({bus.MemW, bus.RegW, bus.IRWrite} !== 3'b0)
         $display("FAIL midrst_hold: got %b expected 000", {bus.MemW, bus.RegW, bus.IRWrite});
      else passed++;
      @(posedge clk);
      #1 reset = 1'b1;
      exp_cnt = 0;
      run_instr("post_rst", 2'b10, 6'b000000, 0, 0);
   endtask

   // Retire DP instructions until the counter rolls over to 0
   task automatic test_wrap();
      int n;
      n = CNT_MOD - exp_cnt;
      for (int i = 0; i < n; i++)
         run_instr("wrap", 2'b00, 6'($urandom), 0, 0);
      checks++;
      if (bus.RetiredCnt !== '0) $display("FAIL wrap_zero: got %0d expected 0", bus.RetiredCnt);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_add();
      test_dp_imm_fetch_stall();
      test_ldr_stall();
      test_str_stall();
      test_branch();
      test_illegal();
      test_random();
      test_reset_mid_write();
      test_wrap();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
